// File: rtl/vga_scanout_pkg.sv
// Shared constants for the VGA scanout slice: default 640x480@60 timing,
// frame-buffer geometry and sync polarity.
package vga_scanout_pkg;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int PIX_W    = 12;
   localparam int ADR_W    = 19;
   localparam int FB_DEPTH = 307200;

   // Wide enough for h[8:6] colour-bar decode and any sane timing override.
   localparam int CNT_W = 12;

   localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider, h/v raster counters and active/sync region decode.
module vga_timing_gen
   import vga_scanout_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             rst,
   output logic             pix_ce,
   output logic [CNT_W-1:0] h,
   output logic [CNT_W-1:0] v,
   output logic             de,
   output logic             hs,
   output logic             vs
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div;

   // Divider sits at 0 out of reset so the first pixel enable lands on the first clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign pix_ce = (div == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (pix_ce) begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   always_comb begin
      de = (h < H_VIS) && (v < V_VIS);
      hs = ((h >= HS_BEGIN) && (h < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs = ((v >= VS_BEGIN) && (v < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout from the frame buffer: one read per visible pixel, 3-clock aligned RGB/sync.
// Optional colour-bar test pattern enabled by defining VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout
   import vga_scanout_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk_i,
   input  logic             rst,
   input  logic             fin_i,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
   input  logic             test_i,
`endif
   output logic             ram_re_o,
   output logic [ADR_W-1:0] ram_adr_o,
   input  logic [PIX_W-1:0] ram_dat_i,
   output logic             vga_hs_o,
   output logic             vga_vs_o,
   output logic [3:0]       vga_r_o,
   output logic [3:0]       vga_g_o,
   output logic [3:0]       vga_b_o,
   output logic             frame_start_o
);

   localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(H_ACTIVE * V_ACTIVE - 1);

   logic             pix_ce;
   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] v;
   logic             de;
   logic             hs;
   logic             vs;

   vga_timing_gen #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(H_ACTIVE),
      .H_FP    (H_FP),
      .H_SYNC  (H_SYNC),
      .H_BP    (H_BP),
      .V_ACTIVE(V_ACTIVE),
      .V_FP    (V_FP),
      .V_SYNC  (V_SYNC),
      .V_BP    (V_BP)
   ) timing (
      .clk   (clk_i),
      .rst   (rst),
      .pix_ce(pix_ce),
      .h     (h),
      .v     (v),
      .de    (de),
      .hs    (hs),
      .vs    (vs)
   );

   logic             at_origin;
   logic             fv_now;
   logic             read_now;
   logic             frame_valid;
   logic [ADR_W-1:0] adr_cnt;
   logic [ADR_W-1:0] adr_now;
   logic             de1, hs1, vs1, fv1;
   logic             de2, hs2, vs2, fv2;
   logic [PIX_W-1:0] pix_next;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
   logic             test_mode;
   logic             tm_now;
   logic             tm1, tm2;
   logic [2:0]       bar1, bar2;
`endif

   // Pixel (0,0) already belongs to the new frame, so it sees the freshly sampled flags.
   always_comb begin
      at_origin = pix_ce && (h == '0) && (v == '0);
      fv_now    = at_origin ? fin_i : frame_valid;
      adr_now   = at_origin ? '0 : adr_cnt;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      tm_now    = at_origin ? test_i : test_mode;
      read_now  = de && fv_now && !tm_now;
`else
      read_now  = de && fv_now;
`endif
   end

   // Stage 1: frame flags, read request, saturating linear address and timing capture.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         frame_valid   <= 1'b0;
         frame_start_o <= 1'b0;
         ram_re_o      <= 1'b0;
         ram_adr_o     <= '0;
         adr_cnt       <= '0;
         de1           <= 1'b0;
         hs1           <= ~SYNC_ACTIVE;
         vs1           <= ~SYNC_ACTIVE;
         fv1           <= 1'b0;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
         test_mode     <= 1'b0;
         tm1           <= 1'b0;
         bar1          <= '0;
`endif
      end else begin
         ram_re_o      <= 1'b0;
         frame_start_o <= 1'b0;
         if (pix_ce) begin
            frame_valid   <= fv_now;
            frame_start_o <= at_origin;
            ram_re_o      <= read_now;
            ram_adr_o     <= adr_now;
            adr_cnt       <= (de && (adr_now != ADR_LAST)) ? adr_now + 1'b1 : adr_now;
            de1           <= de;
            hs1           <= hs;
            vs1           <= vs;
            fv1           <= fv_now;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            test_mode     <= tm_now;
            tm1           <= tm_now;
            bar1          <= h[8:6];
`endif
         end
      end
   end

   always_comb begin
      pix_next = '0;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      if (de2 && tm2) begin
         pix_next = {{4{bar2[2]}}, {4{bar2[1]}}, {4{bar2[0]}}};
      end else if (de2 && fv2) begin
         pix_next = ram_dat_i;
      end
`else
      if (de2 && fv2) begin
         pix_next = ram_dat_i;
      end
`endif
   end

   // Stages 2 and 3 run every clock so the held RAM data lines up with its timing.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         de2      <= 1'b0;
         hs2      <= ~SYNC_ACTIVE;
         vs2      <= ~SYNC_ACTIVE;
         fv2      <= 1'b0;
         vga_hs_o <= ~SYNC_ACTIVE;
         vga_vs_o <= ~SYNC_ACTIVE;
         vga_r_o  <= '0;
         vga_g_o  <= '0;
         vga_b_o  <= '0;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
         tm2      <= 1'b0;
         bar2     <= '0;
`endif
      end else begin
         de2      <= de1;
         hs2      <= hs1;
         vs2      <= vs1;
         fv2      <= fv1;
         vga_hs_o <= hs2;
         vga_vs_o <= vs2;
         {vga_r_o, vga_g_o, vga_b_o} <= pix_next;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
         tm2      <= tm1;
         bar2     <= bar1;
`endif
      end
   end

endmodule
